// File: rtl/ama_riscv_hazard_ctrl_pkg.sv
// ama_riscv_hazard_ctrl_pkg: FSM state encodings, control bundle and hazard helper for the hazard controller.
package ama_riscv_hazard_ctrl_pkg;
   localparam logic [4:0] RF_X0_ZERO  = 5'd0;
   localparam logic [1:0] HZ_INIT     = 2'd0;
   localparam logic [1:0] HZ_RUN      = 2'd1;
   localparam logic [1:0] HZ_MEM_WAIT = 2'd2;
   localparam logic [1:0] HZ_ERR      = 2'd3;

   typedef enum logic [1:0] {
      ST_INIT     = HZ_INIT,
      ST_RUN      = HZ_RUN,
      ST_MEM_WAIT = HZ_MEM_WAIT,
      ST_ERR      = HZ_ERR
   } hz_state_t;

   typedef struct packed {
      logic stall_if;
      logic stall_id;
      logic stall_ex;
      logic stall_mem;
      logic flush_id;
      logic bubble_ex;
   } hz_ctrl_t;

   localparam hz_ctrl_t CTRL_NONE   = 6'b0000_00;
   localparam hz_ctrl_t CTRL_FREEZE = 6'b1111_00;
   localparam hz_ctrl_t CTRL_FLUSH  = 6'b0000_11;
   localparam hz_ctrl_t CTRL_LU     = 6'b1100_01;
   localparam hz_ctrl_t CTRL_INIT   = 6'b1000_11;

   function automatic logic src_hit(input logic used, input logic [4:0] rs, input logic [4:0] rd);
      return used && (rs == rd);
   endfunction
endpackage

// File: rtl/ama_riscv_hazard_ctrl_if.sv
// ama_riscv_hazard_ctrl_if: hazard sources from the pipeline and stall/flush controls back to it.
interface ama_riscv_hazard_ctrl_if;
   logic        load_inst_ex;
   logic        reg_we_ex;
   logic [4:0]  rd_ex;
   logic [4:0]  rs1_id;
   logic [4:0]  rs2_id;
   logic        rs1_used_id;
   logic        rs2_used_id;
   logic        branch_taken_ex;
   logic        jump_ex;
   logic        dmem_req_mem;
   logic        dmem_ready;
   logic        stall_if;
   logic        stall_id;
   logic        stall_ex;
   logic        stall_mem;
   logic        flush_id;
   logic        bubble_ex;
   logic        mem_timeout_err;
   logic [31:0] perf_stall_cycles;
   logic [31:0] perf_flush_cnt;
   logic [31:0] perf_load_use_cnt;

   modport master (
      output load_inst_ex, reg_we_ex, rd_ex, rs1_id, rs2_id, rs1_used_id, rs2_used_id,
             branch_taken_ex, jump_ex, dmem_req_mem, dmem_ready,
      input  stall_if, stall_id, stall_ex, stall_mem, flush_id, bubble_ex, mem_timeout_err,
             perf_stall_cycles, perf_flush_cnt, perf_load_use_cnt
   );

   modport slave (
      input  load_inst_ex, reg_we_ex, rd_ex, rs1_id, rs2_id, rs1_used_id, rs2_used_id,
             branch_taken_ex, jump_ex, dmem_req_mem, dmem_ready,
      output stall_if, stall_id, stall_ex, stall_mem, flush_id, bubble_ex, mem_timeout_err,
             perf_stall_cycles, perf_flush_cnt, perf_load_use_cnt
   );
endinterface

// File: rtl/ama_riscv_hazard_perf.sv
// ama_riscv_hazard_perf: wrap-around stall/flush/load-use event counters (built only with AMA_RISCV_HAZARD_PERF_EN).
module ama_riscv_hazard_perf (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall_evt,
   input  logic        flush_evt,
   input  logic        lu_evt,
   output logic [31:0] perf_stall_cycles,
   output logic [31:0] perf_flush_cnt,
   output logic [31:0] perf_load_use_cnt
);
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         perf_stall_cycles <= '0;
         perf_flush_cnt    <= '0;
         perf_load_use_cnt <= '0;
      end else begin
         perf_stall_cycles <= perf_stall_cycles + 32'(stall_evt);
         perf_flush_cnt    <= perf_flush_cnt + 32'(flush_evt);
         perf_load_use_cnt <= perf_load_use_cnt + 32'(lu_evt);
      end
   end
endmodule

// File: rtl/ama_riscv_hazard_ctrl.sv
// ama_riscv_hazard_ctrl: load-use stall, redirect flush, dmem freeze with timeout watchdog, post-reset flush.
// Optional perf counters under AMA_RISCV_HAZARD_PERF_EN; otherwise the perf ports are tied to 0.
module ama_riscv_hazard_ctrl
   import ama_riscv_hazard_ctrl_pkg::*;
#(
   parameter int RST_FLUSH_CYCLES = 3,
   parameter int MEM_TIMEOUT      = 255
) (
   input logic clk,
   input logic rst_n,
   ama_riscv_hazard_ctrl_if.slave hz
);
   localparam logic [15:0] INIT_LD = 16'(RST_FLUSH_CYCLES - 1);
   localparam logic [15:0] TMO     = 16'(MEM_TIMEOUT);

   hz_state_t   state, state_nxt;
   hz_ctrl_t    run_ctrl, ctrl;
   logic [15:0] init_cnt, wait_cnt;
   logic        load_use, redirect, mem_stall, err;

   assign load_use  = hz.load_inst_ex && hz.reg_we_ex && (hz.rd_ex != RF_X0_ZERO) &&
                      (src_hit(hz.rs1_used_id, hz.rs1_id, hz.rd_ex) ||
                       src_hit(hz.rs2_used_id, hz.rs2_id, hz.rd_ex));
   assign redirect  = hz.branch_taken_ex || hz.jump_ex;
   assign mem_stall = hz.dmem_req_mem && !hz.dmem_ready;
   assign run_ctrl  = mem_stall ? CTRL_FREEZE : redirect ? CTRL_FLUSH : load_use ? CTRL_LU : CTRL_NONE;

   // MEM_WAIT shares the RUN priority table so a release cycle acts on held redirects at once
   always_comb begin
      state_nxt = state;
      ctrl      = CTRL_NONE;
      err       = 1'b0;
      case (state)
         ST_INIT: begin
            ctrl      = CTRL_INIT;
            state_nxt = (init_cnt == '0) ? ST_RUN : ST_INIT;
         end
         ST_RUN: begin
            ctrl      = run_ctrl;
            state_nxt = mem_stall ? ST_MEM_WAIT : ST_RUN;
         end
         ST_MEM_WAIT: begin
            ctrl      = run_ctrl;
            state_nxt = !mem_stall ? ST_RUN : (wait_cnt == TMO) ? ST_ERR : ST_MEM_WAIT;
         end
         ST_ERR: begin
            ctrl = CTRL_FREEZE;
            err  = 1'b1;
         end
         default: state_nxt = ST_INIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= ST_INIT;
         init_cnt <= INIT_LD;
         wait_cnt <= '0;
      end else begin
         state    <= state_nxt;
         init_cnt <= (state == ST_INIT && init_cnt != '0) ? init_cnt - 16'd1 : init_cnt;
         wait_cnt <= (state == ST_RUN && mem_stall) ? 16'd1 :
                     (state == ST_MEM_WAIT && mem_stall && wait_cnt != TMO) ? wait_cnt + 16'd1 : wait_cnt;
      end
   end

   assign hz.stall_if        = ctrl.stall_if;
   assign hz.stall_id        = ctrl.stall_id;
   assign hz.stall_ex        = ctrl.stall_ex;
   assign hz.stall_mem       = ctrl.stall_mem;
   assign hz.flush_id        = ctrl.flush_id;
   assign hz.bubble_ex       = ctrl.bubble_ex;
   assign hz.mem_timeout_err = err;

`ifdef AMA_RISCV_HAZARD_PERF_EN
   logic active;
   assign active = (state == ST_RUN) || (state == ST_MEM_WAIT);

   ama_riscv_hazard_perf u_perf (
      .clk               (clk),
      .rst_n             (rst_n),
      .stall_evt         (state != ST_INIT && (ctrl.stall_if || ctrl.stall_id || ctrl.stall_ex || ctrl.stall_mem)),
      .flush_evt         (active && ctrl.flush_id),
      .lu_evt            (active && ctrl.stall_id && !ctrl.stall_ex),
      .perf_stall_cycles (hz.perf_stall_cycles),
      .perf_flush_cnt    (hz.perf_flush_cnt),
      .perf_load_use_cnt (hz.perf_load_use_cnt)
   );
`else
   assign hz.perf_stall_cycles = '0;
   assign hz.perf_flush_cnt    = '0;
   assign hz.perf_load_use_cnt = '0;
`endif
endmodule

// File: tb/tb_ama_riscv_hazard_ctrl.sv
// tb_ama_riscv_hazard_ctrl: scoreboard bench; expected control vectors are queued per driven cycle.
module tb_ama_riscv_hazard_ctrl;
   // vector order: {stall_if, stall_id, stall_ex, stall_mem, flush_id, bubble_ex, mem_timeout_err}
   localparam logic [6:0] INIT = 7'b1000110;
   localparam logic [6:0] IDLE = 7'b0000000;
   localparam logic [6:0] LUS  = 7'b1100010;
   localparam logic [6:0] RDR  = 7'b0000110;
   localparam logic [6:0] FRZ  = 7'b1111000;
   localparam logic [6:0] ERRV = 7'b1111001;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;
   logic [6:0] exp_q[$];

   ama_riscv_hazard_ctrl_if hz();

   ama_riscv_hazard_ctrl #(.RST_FLUSH_CYCLES(3), .MEM_TIMEOUT(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .hz    (hz)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // flags: {load, we, rs1_used, rs2_used, branch, jump, req, ready}
   task automatic step(input string tag, input logic rn, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [7:0] f, input logic [6:0] exp);
      @(posedge clk);
      #1;
      rst_n = rn;
      hz.rd_ex = rd;
      hz.rs1_id = rs1;
      hz.rs2_id = rs2;
      {hz.load_inst_ex, hz.reg_we_ex, hz.rs1_used_id, hz.rs2_used_id,
       hz.branch_taken_ex, hz.jump_ex, hz.dmem_req_mem, hz.dmem_ready} = f;
      exp_q.push_back(exp);
      @(negedge clk);
      chk(tag, {25'd0, hz.stall_if, hz.stall_id, hz.stall_ex, hz.stall_mem, hz.flush_id,
                hz.bubble_ex, hz.mem_timeout_err}, {25'd0, exp_q.pop_front()});
   endtask

   initial begin
      {hz.load_inst_ex, hz.reg_we_ex, hz.rs1_used_id, hz.rs2_used_id,
       hz.branch_taken_ex, hz.jump_ex, hz.dmem_req_mem, hz.dmem_ready} = '0;
      hz.rd_ex = '0;
      hz.rs1_id = '0;
      hz.rs2_id = '0;
      repeat (2) step("rst", 1'b0, 0, 0, 0, 8'h00, INIT);
      repeat (3) step("init", 1'b1, 0, 0, 0, 8'h00, INIT);
      step("idle", 1'b1, 0, 0, 0, 8'h00, IDLE);
      step("lu_rs2", 1'b1, 5, 0, 5, 8'b1101_0000, LUS);
      step("lu_nop", 1'b1, 0, 0, 5, 8'b0001_0000, IDLE);
      step("lu_x0", 1'b1, 0, 0, 0, 8'b1111_0000, IDLE);
      step("lu_unused", 1'b1, 7, 7, 0, 8'b1100_0000, IDLE);
      step("lu_rs1", 1'b1, 7, 7, 3, 8'b1110_0000, LUS);
      step("lu_nowe", 1'b1, 7, 7, 0, 8'b1010_0000, IDLE);
      step("br_lu", 1'b1, 5, 0, 5, 8'b1101_1000, RDR);
      step("jmp", 1'b1, 0, 0, 0, 8'b0000_0100, RDR);
      repeat (4) step("frz", 1'b1, 0, 0, 0, 8'b0000_0110, FRZ);
      step("rel_jmp", 1'b1, 0, 0, 0, 8'b0000_0101, RDR);
      step("idle2", 1'b1, 0, 0, 0, 8'h00, IDLE);
      step("mem_fast", 1'b1, 0, 0, 0, 8'b0000_0011, IDLE);
      repeat (9) step("tmo_frz", 1'b1, 0, 0, 0, 8'b0000_0010, FRZ);
      repeat (3) step("err", 1'b1, 0, 0, 0, 8'b0000_0010, ERRV);
      step("err_idle", 1'b1, 0, 0, 0, 8'h00, ERRV);
      step("err_rst", 1'b0, 0, 0, 0, 8'h00, ERRV);
      repeat (3) step("reinit", 1'b1, 0, 0, 0, 8'h00, INIT);
      step("idle3", 1'b1, 0, 0, 0, 8'h00, IDLE);
      step("p_lu1", 1'b1, 9, 9, 0, 8'b1110_0000, LUS);
      step("p_nop1", 1'b1, 0, 9, 0, 8'b0010_0000, IDLE);
      step("p_lu2", 1'b1, 4, 0, 4, 8'b1101_0000, LUS);
      step("p_nop2", 1'b1, 0, 0, 4, 8'b0001_0000, IDLE);
      step("p_jmp", 1'b1, 0, 0, 0, 8'b0000_0100, RDR);
      step("idle4", 1'b1, 0, 0, 0, 8'h00, IDLE);
`ifdef AMA_RISCV_HAZARD_PERF_EN
      chk("perf_lu", hz.perf_load_use_cnt, 32'd2);
      chk("perf_flush", hz.perf_flush_cnt, 32'd1);
      chk("perf_stall", hz.perf_stall_cycles, 32'd2);
`else
      chk("perf_lu_tie", hz.perf_load_use_cnt, 32'd0);
      chk("perf_flush_tie", hz.perf_flush_cnt, 32'd0);
      chk("perf_stall_tie", hz.perf_stall_cycles, 32'd0);
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
